// File: rtl/display_pkg.sv
// Shared types, segment encodings and field codes for the multiplexed clock display.
package display_pkg;

    localparam int unsigned SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    // Active-high segment patterns, bit order g..a (bit 0 = a)
    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        CAMP_NONE   = 2'd0,
        CAMP_ORE    = 2'd1,
        CAMP_MINUTE = 2'd2,
        CAMP_RSVD   = 2'd3
    } camp_e;

    // Which time field a scan index belongs to
    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HR   = 2'd2,
        FLD_NONE = 2'd3
    } field_e;

    // One frame's worth of latched display content
    typedef struct packed {
        logic [4:0] ore;
        logic [5:0] minute;
        logic [5:0] secunde;
        logic       set;
    } frame_t;

    function automatic seg_t seg_encode(input logic [3:0] bcd);
        seg_t s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Time/set inputs and scanned display outputs of the seven-segment controller.
interface display_scan_ctrl_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic [4:0]          ore;
    logic [5:0]          minute;
    logic [5:0]          secunde;
    logic [4:0]          ore_setare;
    logic [5:0]          minute_setare;
    logic                semnal_setare;
    logic                semnal_setare_a;
    logic [1:0]          camp_setare;
    logic [N_DIGITS-1:0] digit_select;
    logic [6:0]          digit_display;
    logic                dp;

    modport master (
        output ore, minute, secunde, ore_setare, minute_setare,
               semnal_setare, semnal_setare_a, camp_setare,
        input  digit_select, digit_display, dp
    );

    modport slave (
        input  ore, minute, secunde, ore_setare, minute_setare,
               semnal_setare, semnal_setare_a, camp_setare,
        output digit_select, digit_display, dp
    );
endinterface

// File: rtl/bin2bcd_2d.sv
// Two-digit binary-to-BCD converter with an upper-limit range flag.
module bin2bcd_2d #(
    parameter int unsigned MAX_VAL = 99
) (
    input  logic [6:0] value,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       over
);
    assign tens  = 4'(value / 7'd10);
    assign units = 4'(value % 7'd10);
    assign over  = value > 7'(MAX_VAL);
endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed HH:MM[:SS] seven-segment scanner with frame latching, guard band and field blink.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned GUARD          = 16,
    parameter int unsigned BLINK_DIV      = 12500000,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned SEL_ACTIVE_LOW = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    display_scan_ctrl_if.slave bus
);
    localparam int unsigned PW      = $clog2(SCAN_DIV);
    localparam int unsigned IW      = $clog2(N_DIGITS);
    localparam int unsigned BW      = $clog2(BLINK_DIV);
    localparam int unsigned FLD_OFS = (N_DIGITS == 6) ? 0 : 1;
    localparam logic        SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic        SEL_INV = (SEL_ACTIVE_LOW != 0);
    localparam seg_t                SEG_OFF = SEG_INV ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] SEL_OFF = SEL_INV ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [PW-1:0]       presc_q;
    logic [IW-1:0]       idx_q;
    logic [BW-1:0]       blink_cnt_q;
    logic                blink_phase_q;
    logic                first_q;
    frame_t              cur_q;
    logic [N_DIGITS-1:0] sel_q;
    seg_t                seg_q;
    logic                dp_q;

    logic                set_c;
    frame_t              src_c;
    logic                presc_end_c;
    logic                capture_c;
    field_e              fld_c;
    logic [3:0]          tens_c, units_c, val_c;
    logic                over_c;
    seg_t                seg_c;
    logic                dp_c;
    logic                active_c;
    logic [N_DIGITS-1:0] sel_n;
    seg_t                seg_n;
    logic                dp_n;

    logic [3:0] hr_tens, hr_units, mn_tens, mn_units, sc_tens, sc_units;
    logic       hr_over, mn_over, sc_over;

    // Source select; the set/seconds choice is captured with the data so a frame is coherent
    always_comb begin
        set_c       = bus.semnal_setare | bus.semnal_setare_a;
        src_c       = '0;
        if (set_c) begin
            src_c.ore    = bus.ore_setare;
            src_c.minute = bus.minute_setare;
        end else begin
            src_c.ore     = bus.ore;
            src_c.minute  = bus.minute;
            src_c.secunde = (N_DIGITS == 6) ? bus.secunde : 6'd0;
        end
        src_c.set   = set_c;
        presc_end_c = (presc_q == PW'(SCAN_DIV - 1));
        capture_c   = first_q | (presc_end_c && (idx_q == IW'(N_DIGITS - 1)));
    end

    bin2bcd_2d #(.MAX_VAL(23)) u_bcd_hr (
        .value(7'(cur_q.ore)), .tens(hr_tens), .units(hr_units), .over(hr_over)
    );
    bin2bcd_2d #(.MAX_VAL(59)) u_bcd_mn (
        .value(7'(cur_q.minute)), .tens(mn_tens), .units(mn_units), .over(mn_over)
    );
    bin2bcd_2d #(.MAX_VAL(59)) u_bcd_sc (
        .value(7'(cur_q.secunde)), .tens(sc_tens), .units(sc_units), .over(sc_over)
    );

    // Per-digit segment pattern; even indices are units, odd indices are tens
    always_comb begin
        fld_c   = field_e'(2'(idx_q >> 1) + 2'(FLD_OFS));
        tens_c  = sc_tens;
        units_c = sc_units;
        over_c  = sc_over;
        case (fld_c)
            FLD_HR: begin
                tens_c  = hr_tens;
                units_c = hr_units;
                over_c  = hr_over;
            end
            FLD_MIN: begin
                tens_c  = mn_tens;
                units_c = mn_units;
                over_c  = mn_over;
            end
            default: ;
        endcase
        val_c = idx_q[0] ? tens_c : units_c;
        seg_c = over_c ? SEG_DASH : seg_encode(val_c);
        if (fld_c == FLD_HR && idx_q[0] && tens_c == 4'd0 && !over_c && !cur_q.set)
            seg_c = SEG_BLANK;
        if (set_c && blink_phase_q &&
            ((camp_e'(bus.camp_setare) == CAMP_ORE    && fld_c == FLD_HR) ||
             (camp_e'(bus.camp_setare) == CAMP_MINUTE && fld_c == FLD_MIN)))
            seg_c = SEG_BLANK;
        dp_c     = (fld_c == FLD_HR) && !idx_q[0] && (set_c || !blink_phase_q);
        active_c = (presc_q >= PW'(GUARD));
        sel_n    = active_c ? ((N_DIGITS'(1) << idx_q) ^ SEL_OFF) : SEL_OFF;
        seg_n    = active_c ? (seg_c ^ SEG_OFF) : SEG_OFF;
        dp_n     = (active_c & dp_c) ^ SEG_INV;
    end

    // Scan prescaler, digit index, blink timebase and frame latch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q       <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            first_q       <= 1'b1;
            cur_q         <= '0;
        end else begin
            first_q <= 1'b0;
            if (presc_end_c) begin
                presc_q <= '0;
                idx_q   <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
            if (capture_c)
                cur_q <= src_c;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_q <= SEL_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= SEG_INV;
        end else begin
            sel_q <= sel_n;
            seg_q <= seg_n;
            dp_q  <= dp_n;
        end
    end

    assign bus.digit_select  = sel_q;
    assign bus.digit_display = seg_q;
    assign bus.dp            = dp_q;

endmodule
